// File: rtl/booth_pkg.sv
// Shared types and constants for the shared iterative Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] BOOTH_SUB = 2'b10;
  localparam logic [1:0] BOOTH_ADD = 2'b01;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/booth_radix2_step.sv
// One combinational radix-2 Booth step: add/subtract the multiplicand,
// then arithmetic-shift {A, Q, q_1} right by one.
module booth_radix2_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH:0]   m,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], q_1})
      BOOTH_SUB: sum = a - m;
      BOOTH_ADD: sum = a + m;
      default:   sum = a;
    endcase
    a_next   = {sum[WIDTH], sum[WIDTH:1]};
    q_next   = {sum[0], q[WIDTH-1:1]};
    q_1_next = q[0];
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter in front of one iterative radix-2 Booth multiplier;
// one operation in flight, one Booth step per clock.
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_x,
  input  logic [WIDTH-1:0]   req0_y,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_x,
  input  logic [WIDTH-1:0]   req1_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_z,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t state, state_next;

  // ptr names the requester that wins when both are valid
  logic             ptr;
  logic             grant_id;
  logic             grant_any;
  logic             accept;
  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;

  logic [WIDTH:0]   a_reg, m_reg, a_nx;
  logic [WIDTH-1:0] q_reg, q_nx;
  logic             q1_reg, q1_nx;
  logic [CW-1:0]    cnt;

  booth_radix2_step #(.WIDTH(WIDTH)) u_step (
    .a        (a_reg),
    .m        (m_reg),
    .q        (q_reg),
    .q_1      (q1_reg),
    .a_next   (a_nx),
    .q_next   (q_nx),
    .q_1_next (q1_nx)
  );

  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) grant_id = ptr;
    else                          grant_id = req1_valid;
    sel_x = grant_id ? req1_x : req0_x;
    sel_y = grant_id ? req1_y : req0_y;
  end

  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && grant_any) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_STEP) state_next = DONE;
      end
      DONE: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    rsp_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      cnt    <= '0;
      rsp_z  <= '0;
      rsp_id <= 1'b0;
      a_reg  <= '0;
      m_reg  <= '0;
      q_reg  <= '0;
      q1_reg <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg  <= '0;
            m_reg  <= {sel_y[WIDTH-1], sel_y};
            q_reg  <= sel_x;
            q1_reg <= 1'b0;
            cnt    <= '0;
            rsp_id <= grant_id;
            ptr    <= ~grant_id;
          end
        end
        RUN: begin
          a_reg  <= a_nx;
          q_reg  <= q_nx;
          q1_reg <= q1_nx;
          cnt    <= cnt + 1'b1;
          // the extra A bit is dropped; the low 2*WIDTH bits are the exact product
          if (cnt == LAST_STEP) rsp_z <= {a_nx[WIDTH-1:0], q_nx};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter: reset, corner products, contention,
// backpressure and reset mid-operation, all against hand-computed values.
module tb_booth_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_x, req0_y;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_x, req1_y;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [63:0] rsp_z;

  int tests_run    = 0;
  int tests_failed = 0;

  booth_mul_arbiter #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_z      (rsp_z),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Waits for rsp_valid after the acceptance edge; returns edges counted.
  task automatic waitResponse(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drainResponse();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checkOutput("drain_valid", {63'b0, rsp_valid}, 64'd0);
    checkOutput("drain_busy", {63'b0, busy}, 64'd0);
  endtask

  // Called at a negedge: issue one op on requester id and check its response.
  task automatic applyStimulus(input logic id, input logic [31:0] x, input logic [31:0] y,
                               input logic [63:0] exp_z);
    int waitc;
    int lat;
    if (id) begin req1_valid = 1'b1; req1_x = x; req1_y = y; end
    else    begin req0_valid = 1'b1; req0_x = x; req0_y = y; end
    #1;
    waitc = 0;
    while (!(id ? req1_ready : req0_ready) && waitc < 100) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    checkOutput("grant", {63'b0, (id ? req1_ready : req0_ready)}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    waitResponse(lat);
    checkOutput("latency", 64'(lat), 64'd32);
    checkOutput("rsp_z", rsp_z, exp_z);
    checkOutput("rsp_id", {63'b0, rsp_id}, {63'b0, id});
    drainResponse();
  endtask

  initial begin
    int lat;
    int waitc;
    logic exp_id;
    logic saw_valid;

    rst = 1'b1;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_x = 32'd0; req0_y = 32'd0;
    req1_valid = 1'b1; req1_x = 32'd0; req1_y = 32'd0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("rst_ready0", {63'b0, req0_ready}, 64'd0);
      checkOutput("rst_ready1", {63'b0, req1_ready}, 64'd0);
      checkOutput("rst_valid", {63'b0, rsp_valid}, 64'd0);
      checkOutput("rst_z", rsp_z, 64'd0);
      checkOutput("rst_busy", {63'b0, busy}, 64'd0);
    end
    rst = 1'b0;
    #1;
    checkOutput("first_grant0", {63'b0, req0_ready}, 64'd1);
    checkOutput("first_grant1", {63'b0, req1_ready}, 64'd0);

    applyStimulus(1'b0, 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);

    applyStimulus(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    applyStimulus(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    applyStimulus(1'b0, 32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000);
    applyStimulus(1'b1, 32'd0,         32'hFFFF_FFFF, 64'd0);

    // last grant went to requester 1, so contention starts with requester 0
    req0_valid = 1'b1; req0_x = 32'd5;         req0_y = 32'd7;
    req1_valid = 1'b1; req1_x = 32'hFFFF_FFFD; req1_y = 32'd9;
    for (int op = 0; op < 4; op++) begin
      exp_id = (op % 2) == 1;
      #1;
      waitc = 0;
      while (!(req0_ready || req1_ready) && waitc < 100) begin
        @(negedge clk);
        #1;
        waitc++;
      end
      checkOutput("cont_ready0", {63'b0, req0_ready}, {63'b0, ~exp_id});
      checkOutput("cont_ready1", {63'b0, req1_ready}, {63'b0, exp_id});
      @(posedge clk);
      @(negedge clk);
      #1;
      waitResponse(lat);
      checkOutput("cont_latency", 64'(lat), 64'd32);
      checkOutput("cont_id", {63'b0, rsp_id}, {63'b0, exp_id});
      checkOutput("cont_z", rsp_z, exp_id ? 64'hFFFF_FFFF_FFFF_FFE5 : 64'd35);
      if (op == 0) begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          #1;
          checkOutput("bp_valid", {63'b0, rsp_valid}, 64'd1);
          checkOutput("bp_z", rsp_z, 64'd35);
          checkOutput("bp_id", {63'b0, rsp_id}, 64'd0);
          checkOutput("bp_ready0", {63'b0, req0_ready}, 64'd0);
          checkOutput("bp_ready1", {63'b0, req1_ready}, 64'd0);
          checkOutput("bp_busy", {63'b0, busy}, 64'd1);
        end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    checkOutput("cont_idle", {63'b0, busy}, 64'd0);

    // reset after ten Booth steps must discard the operation
    req0_valid = 1'b1; req0_x = 32'd100; req0_y = 32'd100;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    for (int s = 0; s < 10; s++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_busy", {63'b0, busy}, 64'd0);
    checkOutput("mid_rst_valid", {63'b0, rsp_valid}, 64'd0);
    checkOutput("mid_rst_z", rsp_z, 64'd0);
    saw_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) saw_valid = 1'b1;
    end
    checkOutput("mid_rst_no_rsp", {63'b0, saw_valid}, 64'd0);

    applyStimulus(1'b0, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
